// File: rtl/mult_stage_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mult_stage_pipe_pkg
//   Shared definitions for the multiply-stage pipeline: register-file width
//   defaults, the packed per-stage entry layout and a small helper that
//   normalises an entry before it is captured.
//
//   REG_SIZE / REG_ADDR are normally provided by the project-wide define.v;
//   the guarded fallbacks below keep this slice compilable on its own.
// ---------------------------------------------------------------------------
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

package mult_stage_pipe_pkg;

    localparam int ENTRY_DATA_W = `REG_SIZE;
    localparam int ENTRY_ADDR_W = `REG_ADDR;

    // One pipeline stage worth of state.
    typedef struct packed {
        logic                    valid;
        logic                    regwrite;
        logic [ENTRY_ADDR_W-1:0] dst;
        logic [ENTRY_DATA_W-1:0] result;
        logic                    zero;
        logic                    overflow;
    } stage_entry_t;

    // A bubble must never carry write permission, otherwise a stale
    // regwrite bit could raise a false hazard or leak out at retirement.
    function automatic stage_entry_t gate_entry(input stage_entry_t e);
        stage_entry_t g;
        g          = e;
        g.regwrite = e.valid & e.regwrite;
        return g;
    endfunction

endpackage

// File: rtl/mult_stage_reg.sv
// ---------------------------------------------------------------------------
// mult_stage_reg
//   A single pipeline entry register with enable and flush.
//   Priority: reset > flush > we > hold.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high; clears the whole entry
//     we     - advance enable; 0 holds the entry unchanged
//     flush  - clears valid/regwrite; data fields are left as they are
//     d      - entry presented for capture
//     q      - registered entry
// ---------------------------------------------------------------------------
module mult_stage_reg
    import mult_stage_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic         flush,
    input  stage_entry_t d,
    output stage_entry_t q
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would let an
    // entry ripple through several stages in one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data fields are reset too, not just the control bits,
            // because the registered outputs must read 0 right after reset.
            q <= '0;
        end else if (flush) begin
            q.valid    <= 1'b0;
            q.regwrite <= 1'b0;
        end else if (we) begin
            q <= gate_entry(d);
        end
    end

endmodule

// File: rtl/mult_stage_pipe.sv
// ---------------------------------------------------------------------------
// mult_stage_pipe
//   DEPTH-stage shift pipeline carrying multiply results toward write-back,
//   with a register-hazard query for the decode stage and a live count of
//   valid stages.
//
//   Parameters:
//     DEPTH  - number of stages (1..8)
//     DATA_W - result width
//     ADDR_W - register address width
//
//   Ports:
//     clk, reset                  - clock, synchronous active-high reset
//     we                          - advance enable (0 = whole pipe holds)
//     flush                       - drop every in-flight entry
//     in_valid, regwrite_in,
//     wreg_in, result_in,
//     zero_in, overflow_in        - entry entering stage 0
//     src_a, src_b                - decode-stage source registers
//     out_valid, regwrite_out,
//     result_out, dst_reg,
//     zero, overflow              - registered last-stage fields
//     hazard_a, hazard_b          - src_x is a pending write destination
//     occupancy                   - number of valid stages
// ---------------------------------------------------------------------------
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef REG_ADDR
`define REG_ADDR 5
`endif

module mult_stage_pipe
    import mult_stage_pipe_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int DATA_W = `REG_SIZE,
    parameter int ADDR_W = `REG_ADDR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       regwrite_in,
    input  logic [ADDR_W-1:0]          wreg_in,
    input  logic [DATA_W-1:0]          result_in,
    input  logic                       zero_in,
    input  logic                       overflow_in,
    input  logic [ADDR_W-1:0]          src_a,
    input  logic [ADDR_W-1:0]          src_b,
    output logic                       out_valid,
    output logic                       regwrite_out,
    output logic [DATA_W-1:0]          result_out,
    output logic [ADDR_W-1:0]          dst_reg,
    output logic                       zero,
    output logic                       overflow,
    output logic                       hazard_a,
    output logic                       hazard_b,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    stage_entry_t head_entry;
    stage_entry_t stage_q [DEPTH];
    stage_entry_t last_q;

    assign head_entry = '{
        valid:    in_valid,
        regwrite: regwrite_in,
        dst:      wreg_in,
        result:   result_in,
        zero:     zero_in,
        overflow: overflow_in
    };

    // Stage 0 captures the inputs; every later stage captures its
    // predecessor. DEPTH=1 collapses to a single enabled register.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            mult_stage_reg u_reg (
                .clk   (clk),
                .reset (reset),
                .we    (we),
                .flush (flush),
                .d     (head_entry),
                .q     (stage_q[k])
            );
        end else begin : g_body
            mult_stage_reg u_reg (
                .clk   (clk),
                .reset (reset),
                .we    (we),
                .flush (flush),
                .d     (stage_q[k-1]),
                .q     (stage_q[k])
            );
        end
    end

    assign last_q       = stage_q[DEPTH-1];
    assign out_valid    = last_q.valid;
    assign regwrite_out = last_q.valid & last_q.regwrite;
    assign result_out   = last_q.result;
    assign dst_reg      = last_q.dst;
    assign zero         = last_q.zero;
    assign overflow     = last_q.overflow;

    // Any in-flight write to a non-zero source register is a hazard;
    // register 0 is hard-wired and never pending.
    always_comb begin
        // NOTE: both outputs get a default before the loop so no path
        // leaves them unassigned, which would infer a latch.
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stage_q[k].valid && stage_q[k].regwrite) begin
                if (src_a != '0 && stage_q[k].dst == src_a) hazard_a = 1'b1;
                if (src_b != '0 && stage_q[k].dst == src_b) hazard_b = 1'b1;
            end
        end
    end

    // Counter tracks the valid-bit population without a popcount: an
    // advance adds the incoming entry and removes the retiring one.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (we) begin
            if (in_valid && !last_q.valid) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!in_valid && last_q.valid) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult_stage_pipe
//   Directed bench for mult_stage_pipe (DEPTH=3). A transaction-level model
//   tracks each in-flight instruction by the number of advances it has seen;
//   a negedge process compares every DUT output against it, and the directed
//   sequence pins the model with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mult_stage_pipe;

    localparam int DEPTH = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int OW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, we, flush, in_valid, regwrite_in;
    logic [AW-1:0] wreg_in, src_a, src_b;
    logic [DW-1:0] result_in;
    logic          zero_in, overflow_in;
    logic          out_valid, regwrite_out, zero, overflow, hazard_a, hazard_b;
    logic [DW-1:0] result_out;
    logic [AW-1:0] dst_reg;
    logic [OW-1:0] occupancy;

    mult_stage_pipe #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .flush        (flush),
        .in_valid     (in_valid),
        .regwrite_in  (regwrite_in),
        .wreg_in      (wreg_in),
        .result_in    (result_in),
        .zero_in      (zero_in),
        .overflow_in  (overflow_in),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .regwrite_out (regwrite_out),
        .result_out   (result_out),
        .dst_reg      (dst_reg),
        .zero         (zero),
        .overflow     (overflow),
        .hazard_a     (hazard_a),
        .hazard_b     (hazard_b),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // Each accepted instruction is remembered with the number of advancing
    // edges it has experienced; it is visible at the output once that count
    // reaches DEPTH and gone on the following advance.
    typedef struct {
        bit            rw;
        logic [AW-1:0] dst;
        logic [DW-1:0] res;
        bit            z;
        bit            ov;
        int            age;
    } m_entry_t;

    m_entry_t mq[$];

    always @(posedge clk) begin
        if (reset || flush) begin
            mq.delete();
        end else if (we) begin
            for (int i = 0; i < mq.size(); i++) mq[i].age++;
            while (mq.size() > 0 && mq[0].age > DEPTH) void'(mq.pop_front());
            if (in_valid)
                mq.push_back('{rw: regwrite_in, dst: wreg_in, res: result_in,
                               z: zero_in, ov: overflow_in, age: 1});
        end
    end

    bit exp_v, exp_rw, exp_ha, exp_hb;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_v  = (mq.size() > 0) && (mq[0].age == DEPTH);
            exp_rw = exp_v ? mq[0].rw : 1'b0;
            check("m_out_valid", out_valid, exp_v);
            check("m_regwrite_out", regwrite_out, exp_rw);
            if (exp_v) begin
                check("m_dst_reg", dst_reg, mq[0].dst);
                check("m_result_out", result_out, mq[0].res);
                check("m_zero", zero, mq[0].z);
                check("m_overflow", overflow, mq[0].ov);
            end
            exp_ha = 1'b0;
            exp_hb = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].rw && src_a != 0 && mq[i].dst == src_a) exp_ha = 1'b1;
                if (mq[i].rw && src_b != 0 && mq[i].dst == src_b) exp_hb = 1'b1;
            end
            check("m_hazard_a", hazard_a, exp_ha);
            check("m_hazard_b", hazard_b, exp_hb);
            check("m_occupancy", occupancy, mq.size());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [AW-1:0] d,
                         input logic [DW-1:0] r, input logic z, input logic ov);
        in_valid    = v;
        regwrite_in = rw;
        wreg_in     = d;
        result_in   = r;
        zero_in     = z;
        overflow_in = ov;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        we = 1'b1;
        idle();
        repeat (DEPTH + 1) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        flush = 1'b0;
        src_a = '0;
        src_b = '0;
        idle();
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_regwrite_out", regwrite_out, 1'b0);
        check("rst_result", result_out, 32'h0);
        check("rst_dst", dst_reg, 5'd0);
        check("rst_flags", {zero, overflow}, 2'b00);
        check("rst_occupancy", occupancy, 2'd0);

        // Basic latency: captured on edge 1, visible after edge 3
        we = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'h0000_002A, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        check("lat_not_yet", out_valid, 1'b0);
        tick();
        check("lat_out_valid", out_valid, 1'b1);
        check("lat_regwrite_out", regwrite_out, 1'b1);
        check("lat_dst", dst_reg, 5'd5);
        check("lat_result", result_out, 32'h2A);
        check("lat_occ", occupancy, 2'd1);
        tick();
        check("lat_retired_occ", occupancy, 2'd0);
        check("lat_retired_valid", out_valid, 1'b0);

        // Stall: two held cycles stretch latency to 5 edges
        drive(1'b1, 1'b1, 5'd5, 32'h0000_002A, 1'b0, 1'b0);
        tick();
        we = 1'b0;
        idle();
        tick();
        check("stall_occ_1", occupancy, 2'd1);
        tick();
        check("stall_occ_2", occupancy, 2'd1);
        check("stall_no_out", out_valid, 1'b0);
        we = 1'b1;
        tick();
        check("stall_edge4_no_out", out_valid, 1'b0);
        tick();
        check("stall_edge5_out", out_valid, 1'b1);
        check("stall_edge5_dst", dst_reg, 5'd5);
        drain();

        // Hazards with two writers held in flight
        drive(1'b1, 1'b1, 5'd7, 32'h0000_0007, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd9, 32'h0000_0009, 1'b0, 1'b0);
        tick();
        we = 1'b0;
        idle();
        src_a = 5'd7;
        src_b = 5'd0;
        #1;
        check("haz_a_7", hazard_a, 1'b1);
        check("haz_b_0", hazard_b, 1'b0);
        src_b = 5'd9;
        #1;
        check("haz_b_9", hazard_b, 1'b1);
        we = 1'b1;
        repeat (3) tick();
        check("haz_a_gone", hazard_a, 1'b0);
        check("haz_b_gone", hazard_b, 1'b0);

        // No write permission -> no hazard, regwrite_out low at retirement
        drive(1'b1, 1'b0, 5'd4, 32'h0000_0044, 1'b1, 1'b0);
        tick();
        idle();
        src_a = 5'd4;
        src_b = 5'd0;
        #1;
        check("norw_haz_a", hazard_a, 1'b0);
        tick();
        tick();
        check("norw_out_valid", out_valid, 1'b1);
        check("norw_regwrite_out", regwrite_out, 1'b0);
        check("norw_zero", zero, 1'b1);
        drain();

        // Register 0 never raises a hazard
        drive(1'b1, 1'b1, 5'd0, 32'h0000_0001, 1'b0, 1'b1);
        tick();
        idle();
        src_a = 5'd0;
        #1;
        check("r0_haz_a", hazard_a, 1'b0);
        drain();

        // Flush a full pipe while another entry is presented
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i * 16), 1'b0, 1'b0);
            tick();
        end
        check("full_occ", occupancy, 2'd3);
        flush = 1'b1;
        drive(1'b1, 1'b1, 5'd6, 32'h0000_0066, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        we    = 1'b0;
        idle();
        src_a = 5'd6;
        src_b = 5'd1;
        #1;
        check("flush_occ", occupancy, 2'd0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_regwrite_out", regwrite_out, 1'b0);
        check("flush_haz", {hazard_a, hazard_b}, 2'b00);
        we = 1'b1;

        // Mixed stream: bubbles, stalls, flags, and one flush
        for (int i = 0; i < 24; i++) begin
            we    = (i % 5 != 3);
            flush = (i == 17);
            drive(i % 3 != 2, i % 2 == 0, AW'(i + 1), 32'hA5A5_0000 + DW'(i),
                  i % 4 == 0, i % 7 == 0);
            src_a = AW'(i);
            src_b = AW'(i + 3);
            tick();
        end
        flush = 1'b0;
        drain();

        // Reset mid-stream with a valid entry in stage 1
        drive(1'b1, 1'b1, 5'd8, 32'h0000_0055, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_result", result_out, 32'h0);
        check("mrst_dst", dst_reg, 5'd0);
        check("mrst_occ", occupancy, 2'd0);
        repeat (3) begin
            tick();
            check("mrst_never_out", out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
